seq_divider: RTL and testbench

- Multi-cycle 32-bit integer divider for the datapath ALU; serves DIV/DIVU/REM-class instructions.
- Converts signed operands to magnitudes, runs a 32-iteration restoring division, then applies result signs.
- The control unit stalls on `busy` and captures results on `done`.

---
 rtl/seq_divider_pkg.sv | 17 +
 rtl/seq_divider_complement2s.sv | 14 +
 rtl/seq_divider.sv | 166 ++++++++++++++++
 tb/tb_seq_divider.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared constants and state encoding for the sequential integer divider.
// The ALU datapath is 32 bits wide; the constants below are sized to match.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam logic [DIV_WIDTH-1:0] DBZ_QUOT = '1;
  localparam logic [DIV_WIDTH-1:0] MIN_INT  = {1'b1, {(DIV_WIDTH-1){1'b0}}};
  localparam logic [DIV_WIDTH-1:0] ALL_ONES = '1;

endpackage

// File: rtl/seq_divider_complement2s.sv
// Purely combinational two's-complement negator used for operand magnitudes
// and result sign correction.
module Complement2s
  import seq_divider_pkg::*;
#(
  parameter int W = DIV_WIDTH
) (
  input  logic [W-1:0] a_i,
  output logic [W-1:0] neg_o
);

  assign neg_o = ~a_i + W'(1);

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: magnitudes in, 32 shift/subtract iterations,
// then signs reapplied in a single fix-up cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_quo_q, sgn_quo_d, sgn_rem_q, sgn_rem_d;
  logic             dbz_pend_q, dbz_pend_d, ovf_pend_q, ovf_pend_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             dbz_q, dbz_d, ovf_q, ovf_d;

  logic [WIDTH-1:0] neg_dividend, neg_divisor, neg_q, neg_acc;
  logic [WIDTH-1:0] mag_dividend, mag_divisor;
  logic [WIDTH:0]   acc_sh;
  logic             no_borrow;

  Complement2s #(.W(WIDTH)) u_neg_dividend (.a_i(dividend), .neg_o(neg_dividend));
  Complement2s #(.W(WIDTH)) u_neg_divisor  (.a_i(divisor),  .neg_o(neg_divisor));
  Complement2s #(.W(WIDTH)) u_neg_quo      (.a_i(q_q),      .neg_o(neg_q));
  Complement2s #(.W(WIDTH)) u_neg_rem      (.a_i(acc_q),    .neg_o(neg_acc));

  assign mag_dividend = (signed_op && dividend[WIDTH-1]) ? neg_dividend : dividend;
  assign mag_divisor  = (signed_op && divisor[WIDTH-1])  ? neg_divisor  : divisor;

  // acc_sh carries one extra bit so the trial compare never loses the shifted-out MSB.
  assign acc_sh    = {acc_q, q_q[WIDTH-1]};
  assign no_borrow = (acc_sh >= {1'b0, dvsr_q});

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    q_d        = q_q;
    dvsr_d     = dvsr_q;
    cnt_d      = cnt_q;
    sgn_quo_d  = sgn_quo_q;
    sgn_rem_d  = sgn_rem_q;
    dbz_pend_d = dbz_pend_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sgn_quo_d  = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          sgn_rem_d  = signed_op & dividend[WIDTH-1];
          dvsr_d     = mag_divisor;
          cnt_d      = '0;
          busy_d     = 1'b1;
          dbz_pend_d = (divisor == '0);
          ovf_pend_d = signed_op && (dividend == WIDTH'(MIN_INT)) &&
                       (divisor == WIDTH'(ALL_ONES));
          if (divisor == '0) begin
            // Divide-by-zero results bypass sign correction entirely.
            q_d       = WIDTH'(DBZ_QUOT);
            acc_d     = dividend;
            sgn_quo_d = 1'b0;
            sgn_rem_d = 1'b0;
            state_d   = ST_FIX;
          end else begin
            q_d     = mag_dividend;
            acc_d   = '0;
            state_d = ST_DIV;
          end
        end
      end

      ST_DIV: begin
        if (no_borrow) begin
          acc_d = acc_sh[WIDTH-1:0] - dvsr_q;
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = acc_sh[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        quo_d   = sgn_quo_q ? neg_q : q_q;
        rem_d   = sgn_rem_q ? neg_acc : acc_q;
        dbz_d   = dbz_pend_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      q_q        <= '0;
      dvsr_q     <= '0;
      cnt_q      <= '0;
      sgn_quo_q  <= 1'b0;
      sgn_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      q_q        <= q_d;
      dvsr_q     <= dvsr_d;
      cnt_q      <= cnt_d;
      sgn_quo_q  <= sgn_quo_d;
      sgn_rem_q  <= sgn_rem_d;
      dbz_pend_q <= dbz_pend_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed operations push expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] quotient, remainder;

  int n_checks = 0;
  int n_fail = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          edge_no;
    string       nm;
  } exp_t;

  exp_t sb[$];

  seq_divider dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got quotient %h expected no done", quotient);
        end else begin
          e = sb.pop_front();
          chk({e.nm, "_quotient"}, quotient, e.q);
          chk({e.nm, "_remainder"}, remainder, e.r);
          chk({e.nm, "_dbz"}, {31'b0, div_by_zero}, {31'b0, e.dbz});
          chk({e.nm, "_ovf"}, {31'b0, overflow}, {31'b0, e.ovf});
          chk({e.nm, "_latency_edge"}, edge_cnt, e.edge_no);
          chk({e.nm, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        end
      end
    end
  end

  // inject > 0 pulses a second start that many cycles into the operation.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic edbz, input logic eovf, input int lat,
                       input int inject, input string nm);
    exp_t e;
    logic seen;
    logic bad_busy;
    @(negedge clk);
    signed_op = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf;
    e.edge_no = edge_cnt + lat;
    e.nm = nm;
    sb.push_back(e);
    seen = 1'b0;
    bad_busy = 1'b0;
    for (int i = 1; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else if (busy !== 1'b1) bad_busy = 1'b1;
      if (inject > 0 && i == inject) begin
        signed_op = 1'b0;
        dividend  = 32'd5;
        divisor   = 32'd0;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({nm, "_busy_during_op"}, {31'b0, bad_busy}, 32'd0);
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done within 60 cycles", nm);
    end
  endtask

  initial begin : driver
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_flags", {30'b0, div_by_zero, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(1'b1, 32'd100,        32'd7,        32'h0000000E, 32'd2,        1'b0, 1'b0, 33, 0, "s_100_7");
    do_op(1'b1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 33, 0, "s_m100_7");
    do_op(1'b1, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0, 33, 0, "s_100_m7");
    do_op(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 33, 0, "s_m100_m7");
    do_op(1'b1, 32'd7,          32'd0,        32'hFFFFFFFF, 32'd7,        1'b1, 1'b0, 1,  0, "s_7_0");
    do_op(1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1, 33, 0, "s_ovf");
    do_op(1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b0, 33, 0, "u_min_ones");
    do_op(1'b0, 32'hFFFFFFFF,   32'd2,        32'h7FFFFFFF, 32'd1,        1'b0, 1'b0, 33, 0, "u_max_2");
    do_op(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0, 33, 0, "u_max_max");
    do_op(1'b0, 32'd5,          32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1'b0, 1,  0, "u_5_0");
    do_op(1'b1, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1'b0, 1,  0, "s_m7_0");
    do_op(1'b0, 32'd3,          32'd10,       32'd0,        32'd3,        1'b0, 1'b0, 33, 0, "u_3_10");
    do_op(1'b0, 32'd1000,       32'd10,       32'd100,      32'd0,        1'b0, 1'b0, 33, 10, "start_while_busy");

    repeat (5) @(negedge clk);
    chk("idle_after_ignored_start", {31'b0, busy}, 32'd0);

    // Abort mid-operation; no result is expected from this request.
    @(negedge clk);
    signed_op = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (16) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_flags", {30'b0, div_by_zero, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("idle_after_abort_busy", {31'b0, busy}, 32'd0);
    chk("idle_after_abort_quotient", quotient, 32'd0);

    do_op(1'b1, 32'd200, 32'd3, 32'd66, 32'd2, 1'b0, 1'b0, 33, 0, "after_abort");

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
